// File: rtl/debounce_pkg.sv
// debounce_pkg: shared defaults and helpers for the multi-channel debouncer.
//   DEFAULT_DEBOUNCE_CLKS : stability window in clocks when no override is given
//   DEFAULT_SYNC_STAGES   : synchroniser depth when no override is given
//   us_to_clks()          : converts a microsecond settle time into a clock count
package debounce_pkg;

   localparam int DEFAULT_DEBOUNCE_CLKS = 10_000;
   localparam int DEFAULT_SYNC_STAGES   = 2;

   // Rounds up so the real settle time is never shorter than requested.
   // The result is clamped to 2, the smallest window the debouncer accepts.
   function automatic int unsigned us_to_clks(input int unsigned delay_us,
                                              input longint unsigned clk_hz);
      longint unsigned clks;
      clks = (64'(delay_us) * clk_hz + 64'd999_999) / 64'd1_000_000;
      if (clks < 64'd2) clks = 64'd2;
      return 32'(clks);
   endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// debounce_multi_if: pin-side and control-side signals of the debouncer.
//   async_in     : raw asynchronous inputs (driven by the board side)
//   debounce_out : debounced level per channel
//   rise_pulse   : one-cycle 0->1 event per channel
//   fall_pulse   : one-cycle 1->0 event per channel
//   busy         : channel has a candidate change pending
// master drives async_in and observes the results; slave is the debouncer.
interface debounce_multi_if #(
   parameter int NUM_CH = 4
);
   logic [NUM_CH-1:0] async_in;
   logic [NUM_CH-1:0] debounce_out;
   logic [NUM_CH-1:0] rise_pulse;
   logic [NUM_CH-1:0] fall_pulse;
   logic [NUM_CH-1:0] busy;

   modport master (output async_in,
                   input  debounce_out, rise_pulse, fall_pulse, busy);
   modport slave  (input  async_in,
                   output debounce_out, rise_pulse, fall_pulse, busy);
endinterface

// File: rtl/debounce_channel.sv
// debounce_channel: single-bit synchroniser, stability counter and edge pulses.
//   clk, rst     : system clock, synchronous active-high reset
//   async_in     : raw asynchronous input
//   debounce_out : registered debounced level
//   rise_pulse   : high for the first cycle debounce_out reads 1 after a 0
//   fall_pulse   : high for the first cycle debounce_out reads 0 after a 1
//   busy         : mismatch counter is nonzero
module debounce_channel #(
   parameter int   DEBOUNCE_CLKS = 10_000,
   parameter int   SYNC_STAGES   = 2,
   parameter logic RESET_VALUE   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic debounce_out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic busy
);

   localparam int             CW      = $clog2(DEBOUNCE_CLKS);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CLKS - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt_q;
   logic                   sync_s;
   logic                   mismatch;
   logic                   flip;

   assign sync_s   = sync_q[SYNC_STAGES-1];
   assign mismatch = (sync_s != debounce_out);
   // Flip on the DEBOUNCE_CLKS-th consecutive mismatch: counter already holds
   // the previous DEBOUNCE_CLKS-1 mismatches.
   assign flip     = mismatch && (cnt_q == CNT_MAX);
   assign busy     = (cnt_q != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q       <= {SYNC_STAGES{RESET_VALUE}};
         debounce_out <= RESET_VALUE;
         cnt_q        <= '0;
         rise_pulse   <= 1'b0;
         fall_pulse   <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], async_in};
         // Pulses register alongside debounce_out so both are visible together.
         rise_pulse <= flip &  sync_s;
         fall_pulse <= flip & ~sync_s;
         // Any matching cycle clears the count: runts never accumulate.
         if (!mismatch || flip) cnt_q <= '0;
         else                   cnt_q <= cnt_q + CW'(1);
         if (flip) debounce_out <= sync_s;
      end
   end

endmodule

// File: rtl/debounce_multi.sv
// debounce_multi: NUM_CH independent debouncers for buttons and switches.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : debounce_multi_if.slave (async_in in; debounce_out, rise_pulse,
//              fall_pulse, busy out), each NUM_CH bits wide
// The interface instance must be built with the same NUM_CH.
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int              NUM_CH        = 4,
   parameter int              DEBOUNCE_CLKS = DEFAULT_DEBOUNCE_CLKS,
   parameter int              SYNC_STAGES   = DEFAULT_SYNC_STAGES,
   parameter logic [NUM_CH-1:0] RESET_VALUE = '0
) (
   input  logic              clk,
   input  logic              rst,
   debounce_multi_if.slave   bus
);

   if (NUM_CH < 1)        begin : g_bad_ch   $error("NUM_CH must be >= 1");        end
   if (DEBOUNCE_CLKS < 2) begin : g_bad_clks $error("DEBOUNCE_CLKS must be >= 2"); end
   if (SYNC_STAGES < 2)   begin : g_bad_sync $error("SYNC_STAGES must be >= 2");   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CLKS (DEBOUNCE_CLKS),
         .SYNC_STAGES   (SYNC_STAGES),
         .RESET_VALUE   (RESET_VALUE[i])
      ) u_ch (
         .clk          (clk),
         .rst          (rst),
         .async_in     (bus.async_in[i]),
         .debounce_out (bus.debounce_out[i]),
         .rise_pulse   (bus.rise_pulse[i]),
         .fall_pulse   (bus.fall_pulse[i]),
         .busy         (bus.busy[i])
      );
   end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised successor to the single-bit debouncer.
- Debounces NUM_CH independent asynchronous inputs (buttons, switches) in one block.
- Each channel has its own synchroniser, its own stability counter, and single-cycle rise/fall event pulses.
- Sits between board I/O pins and control logic such as the TX trigger and mode switches.

Parameters:
- NUM_CH, 4: number of independent channels; must be ≥1.
- DEBOUNCE_CLKS, 10_000: consecutive mismatch cycles needed before an output flips; must be ≥2.
- SYNC_STAGES, 2: flip-flops in each input synchroniser chain; must be ≥2.
- RESET_VALUE, '0: NUM_CH-bit value loaded into the synchronisers and debounce_out at reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- async_in  in  NUM_CH  raw asynchronous inputs.
- debounce_out  out  NUM_CH  debounced, registered level per channel.
- rise_pulse  out  NUM_CH  one-cycle pulse when a channel's debounce_out goes 0→1.
- fall_pulse  out  NUM_CH  one-cycle pulse when a channel's debounce_out goes 1→0.
- busy  out  NUM_CH  high while the channel counter is nonzero, i.e. a candidate change is pending.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Reset (rst high at a posedge):
  - Sync chains and debounce_out load RESET_VALUE.
  - Counters load 0.
  - rise_pulse, fall_pulse and busy are 0 in the cycle after reset.
- Reset mid-count discards any pending change. There are no edge pulses caused by reset itself.
- Synchroniser: async_in[i] passes through SYNC_STAGES flops. The last stage is sync[i].
- Per-channel counter, width $clog2(DEBOUNCE_CLKS), evaluated each posedge:
  - sync == debounce_out: counter ← 0.
  - sync != debounce_out and counter < DEBOUNCE_CLKS-1: counter ← counter+1.
  - sync != debounce_out and counter == DEBOUNCE_CLKS-1: debounce_out ← sync, counter ← 0, and the matching pulse fires.
- Rule: the output flips on the DEBOUNCE_CLKS-th consecutive posedge at which sync differs from debounce_out.
- Latency:
  - async_in changes and is held stable before posedge P0.
  - debounce_out changes after posedge P0+SYNC_STAGES+DEBOUNCE_CLKS-1.
  - Total is exactly SYNC_STAGES+DEBOUNCE_CLKS cycles ±0 once the input is past the synchroniser.
- Runt rejection:
  - Any single cycle with sync == debounce_out clears the counter.
  - Mismatch cycles never accumulate across bounces, including alternating 1-cycle bounces.
- Edge pulses:
  - rise_pulse[i] and fall_pulse[i] are registered and high for exactly the cycle in which the new debounce_out value is first visible.
  - They are mutually exclusive per channel.
- busy[i] = (counter[i] != 0), combinational from the registered counter.
- Channels are fully independent. Simultaneous events on different channels produce simultaneous pulses.
- The counter never exceeds DEBOUNCE_CLKS-1, so there is no wrap-around.
- Elaboration-time assertions reject:
  - DEBOUNCE_CLKS < 2
  - SYNC_STAGES < 2
  - NUM_CH < 1

Decomposition:
- Package debounce_pkg holds:
  - DEFAULT_DEBOUNCE_CLKS
  - DEFAULT_SYNC_STAGES
  - a function us_to_clks(delay_us, clk_hz) for computing DEBOUNCE_CLKS from a microsecond delay.
- One sub-module, debounce_channel, contains a single-bit synchroniser, counter and pulse logic.
- debounce_multi is a generate loop of NUM_CH debounce_channel instances.

Test Plan (NUM_CH=4, DEBOUNCE_CLKS=16, SYNC_STAGES=2, RESET_VALUE=4'b0000):
1. Reset with async_in=4'b1111 held → debounce_out=0000, pulses 0 and busy 0 through reset; debounce_out=1111 exactly 18 cycles after the first post-reset posedge, with rise_pulse=1111 for 1 cycle.
2. Ch0 0→1 clean step at a negedge → debounce_out[0] stays 0 for 17 posedges and is 1 after the 18th; rise_pulse[0] is high 1 cycle; channels 1-3 are unchanged.
3. Ch1 runt high for 15 cycles, then low → debounce_out[1] and both pulses stay 0 for 100 cycles; busy[1] returns to 0 within 3 cycles of the runt ending.
4. Ch2 alternating 1-cycle bounce for 200 cycles, then held high → no change during bouncing; debounce_out[2] rises exactly 18 cycles after the final hold begins.
5. Ch3 and ch0 released simultaneously (1→0) → fall_pulse=4'b1001 in the same cycle; rise_pulse stays 0.
6. rst asserted at counter=10 on ch1 → debounce_out[1] stays at RESET_VALUE, no pulse fires, and the full 18-cycle latency restarts after reset is released.
